vedic_mul_seq_ctrl: RTL

//  Sequencing controller that builds a wide unsigned (optionally signed) multiply from one shared

---
 rtl/vedic_mul_seq_ctrl_pkg.sv | 35 +++
 rtl/vedic_8x8.sv | 19 +
 rtl/vedic_mul_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vedic_mul_seq_ctrl_pkg.sv
// Shared types and helpers for the byte-serial Vedic multiply controller.
// State encodings, default operand width, and the combinational Vedic building blocks.
package vedic_mul_seq_ctrl_pkg;

  localparam int ZILLA_MUL_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Byte counters need at least one bit, even when the operand is a single byte.
  function automatic int byte_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Urdhva-Tiryagbhyam 2x2: vertical and crosswise terms with one explicit carry.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic c;
    c = a[1] & b[0] & a[0] & b[1];
    return {a[1] & b[1] & c, (a[1] & b[1]) ^ c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
  endfunction

  function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ll, hl, lh, hh;
    ll = vedic_2x2(a[1:0], b[1:0]);
    hl = vedic_2x2(a[3:2], b[1:0]);
    lh = vedic_2x2(a[1:0], b[3:2]);
    hh = vedic_2x2(a[3:2], b[3:2]);
    return {hh, ll} + {2'b00, hl, 2'b00} + {2'b00, lh, 2'b00};
  endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Purely combinational 8x8 unsigned Vedic multiplier, built from four 4x4 Vedic blocks.
module vedic_8x8
  import vedic_mul_seq_ctrl_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [7:0] ll, hl, lh, hh;

  assign ll = vedic_4x4(a[3:0], b[3:0]);
  assign hl = vedic_4x4(a[7:4], b[3:0]);
  assign lh = vedic_4x4(a[3:0], b[7:4]);
  assign hh = vedic_4x4(a[7:4], b[7:4]);

  assign p = {hh, ll} + {4'b0000, hl, 4'b0000} + {4'b0000, lh, 4'b0000};

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Byte-serial wide multiplier: one 8x8 Vedic partial product accumulated per cycle.
// Optional signed operands are enabled by defining ZILLA_MUL_SIGNED_EN.
module vedic_mul_seq_ctrl
  import vedic_mul_seq_ctrl_pkg::*;
#(
  parameter  int N_BYTES = ZILLA_MUL_BYTES,
  localparam int W       = 8 * N_BYTES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
`ifdef ZILLA_MUL_SIGNED_EN
  input  logic           a_signed,
  input  logic           b_signed,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           busy
);

  localparam int              IW       = byte_idx_w(N_BYTES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_BYTES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [15:0]      pp;
  logic [2*W-1:0]   pp_ext, pp_shifted;
  logic [IW+3:0]    shamt;

`ifdef ZILLA_MUL_SIGNED_EN
  assign a_neg = a_signed & a_in[W-1];
  assign b_neg = b_signed & b_in[W-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // The most-negative value negates to itself, which read unsigned is exactly 2^(W-1).
  assign a_mag = a_neg ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_neg ? (~b_in + 1'b1) : b_in;

  vedic_8x8 u_vedic_8x8 (
    .a (a_q[8*i_q +: 8]),
    .b (b_q[8*j_q +: 8]),
    .p (pp)
  );

  // Byte pair (i,j) carries weight 2^(8*(i+j)).
  assign shamt      = {(IW+1)'(i_q) + (IW+1)'(j_q), 3'b000};
  assign pp_ext     = (2*W)'(pp);
  assign pp_shifted = pp_ext << shamt;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    neg_d   = neg_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
`ifdef ZILLA_MUL_SIGNED_EN
            state_d = neg_q ? S_NEG : S_DONE;
`else
            state_d = S_DONE;
`endif
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_NEG: begin
        acc_d   = ~acc_q + 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered, derived from the state being entered.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule
